linebuffer_2x2_frame_ctrl: RTL and testbench

Frame sequencer for the 8-channel 2x2 line-buffer collector used ahead of the int4 2x2/stride-2 pooling stage. It latches the feature-map size code (`sel`) for one frame and drives it to all eight line buffers. It accepts a contiguous pixel stream and tracks row and column, then marks which line-buffer output cycles carry a complete non-overlapping 2x2 window. It also reports frame completion and protocol errors.

---
 rtl/lb_pkg.sv | 39 +++
 rtl/lb_win_delay.sv | 46 ++++
 rtl/linebuffer_2x2_frame_ctrl.sv | 149 ++++++++++++++
 tb/tb_linebuffer_2x2_frame_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lb_pkg.sv
// Shared definitions for the 2x2 line-buffer collector: size codes,
// the size-code-to-width decode, controller state encoding and the
// pooled window-coordinate width.
package lb_pkg;

  localparam logic [2:0] SEL_16  = 3'd0;
  localparam logic [2:0] SEL_14  = 3'd1;
  localparam logic [2:0] SEL_28  = 3'd2;
  localparam logic [2:0] SEL_56  = 3'd3;
  localparam logic [2:0] SEL_112 = 3'd4;
  localparam logic [2:0] SEL_224 = 3'd5;

  localparam int WIN_COORD_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } lb_state_e;

  // Square feature-map width for a size code; illegal codes decode to 0.
  function automatic logic [7:0] sel_to_width(input logic [2:0] sel);
    case (sel)
      SEL_16:  return 8'd16;
      SEL_14:  return 8'd14;
      SEL_28:  return 8'd28;
      SEL_56:  return 8'd56;
      SEL_112: return 8'd112;
      SEL_224: return 8'd224;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic sel_is_legal(input logic [2:0] sel);
    return (sel <= SEL_224);
  endfunction

endpackage

// File: rtl/lb_win_delay.sv
// WIN_LAT-stage delay line carrying {valid, row, col} of a completed
// 2x2 window so it lines up with the line-buffer outputs.
module lb_win_delay
  import lb_pkg::*;
#(
  parameter int WIN_LAT = 1
) (
  input  logic                   clk,
  input  logic                   i_clr,
  input  logic                   i_vld,
  input  logic [WIN_COORD_W-1:0] i_row,
  input  logic [WIN_COORD_W-1:0] i_col,
  output logic                   o_vld,
  output logic [WIN_COORD_W-1:0] o_row,
  output logic [WIN_COORD_W-1:0] o_col
);

  logic                   r_vld [WIN_LAT];
  logic [WIN_COORD_W-1:0] r_row [WIN_LAT];
  logic [WIN_COORD_W-1:0] r_col [WIN_LAT];

  // Shift one stage per clock; a clear empties every stage at once.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int i = 0; i < WIN_LAT; i++) begin
        r_vld[i] <= 1'b0;
        r_row[i] <= '0;
        r_col[i] <= '0;
      end
    end else begin
      r_vld[0] <= i_vld;
      r_row[0] <= i_row;
      r_col[0] <= i_col;
      for (int i = 1; i < WIN_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_row[i] <= r_row[i-1];
        r_col[i] <= r_col[i-1];
      end
    end
  end

  assign o_vld = r_vld[WIN_LAT-1];
  assign o_row = r_row[WIN_LAT-1];
  assign o_col = r_col[WIN_LAT-1];

endmodule

// File: rtl/linebuffer_2x2_frame_ctrl.sv
// Frame sequencer for the 8-channel 2x2 line-buffer collector: latches
// the size code, tracks row/col of a contiguous pixel stream, flags the
// cycles carrying complete non-overlapping 2x2 windows, and reports
// frame completion and protocol errors.
module linebuffer_2x2_frame_ctrl
  import lb_pkg::*;
#(
  parameter int WIN_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             cfg_sel,
  input  logic                   start,
  input  logic                   in_valid,
  output logic [2:0]             lb_sel,
  output logic                   in_ready,
  output logic                   win_valid,
  output logic [WIN_COORD_W-1:0] win_row,
  output logic [WIN_COORD_W-1:0] win_col,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err,
  output logic                   gap_err
);

  lb_state_e  r_state;
  lb_state_e  w_next;
  logic [7:0] r_col;
  logic [7:0] r_row;
  logic [2:0] r_lb_sel;
  logic [2:0] r_flush_cnt;
  logic       r_done;
  logic       r_cfg_err;
  logic       r_gap_err;

  logic [7:0] w_width;
  logic       w_in_ready;
  logic       w_busy;
  logic       w_accept;
  logic       w_beat;
  logic       w_col_end;
  logic       w_row_end;
  logic       w_last;
  logic       w_gap;
  logic       w_push;
  logic       w_flush_end;
  logic       w_dl_clr;

  assign w_width     = sel_to_width(r_lb_sel);
  assign w_accept    = (r_state == ST_IDLE) && start && sel_is_legal(cfg_sel);
  assign w_beat      = in_valid && w_in_ready;
  assign w_col_end   = (r_col == w_width - 8'd1);
  assign w_row_end   = (r_row == w_width - 8'd1);
  assign w_last      = w_col_end && w_row_end;
  assign w_gap       = (r_state == ST_RUN) && !in_valid;
  // Odd row and odd column closes a non-overlapping 2x2 window.
  assign w_push      = w_beat && r_row[0] && r_col[0];
  assign w_flush_end = (r_state == ST_FLUSH) && (r_flush_cnt == 3'(WIN_LAT - 1));
  // A broken stream invalidates any window still in flight.
  assign w_dl_clr    = rst || w_gap;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_ARM;
      ST_ARM:   if (in_valid) w_next = ST_RUN;
      ST_RUN: begin
        if (!in_valid)   w_next = ST_IDLE;
        else if (w_last) w_next = ST_FLUSH;
      end
      ST_FLUSH: if (w_flush_end) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    w_in_ready = (r_state == ST_ARM) || (r_state == ST_RUN);
    w_busy     = (r_state != ST_IDLE);
  end

  // Pixel position counters; col wraps at W-1 and carries into row.
  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_beat) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? 8'd0 : r_row + 8'd1;
      end else begin
        r_col <= r_col + 8'd1;
      end
    end
  end

  // Drain timer for FLUSH; restarts whenever the state is elsewhere.
  always_ff @(posedge clk) begin
    if (rst || (r_state != ST_FLUSH)) r_flush_cnt <= '0;
    else                              r_flush_cnt <= r_flush_cnt + 3'd1;
  end

  // Frame configuration, completion pulse and error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lb_sel  <= '0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      r_gap_err <= 1'b0;
    end else begin
      r_done    <= w_flush_end;
      r_cfg_err <= (r_state == ST_IDLE) && start && !sel_is_legal(cfg_sel);
      if (w_accept) begin
        r_lb_sel  <= cfg_sel;
        r_gap_err <= 1'b0;
      end else if (w_gap) begin
        r_gap_err <= 1'b1;
      end
    end
  end

  lb_win_delay #(
    .WIN_LAT (WIN_LAT)
  ) u_win_delay (
    .clk   (clk),
    .i_clr (w_dl_clr),
    .i_vld (w_push),
    .i_row (r_row[7:1]),
    .i_col (r_col[7:1]),
    .o_vld (win_valid),
    .o_row (win_row),
    .o_col (win_col)
  );

  assign lb_sel   = r_lb_sel;
  assign in_ready = w_in_ready;
  assign busy     = w_busy;
  assign done     = r_done;
  assign cfg_err  = r_cfg_err;
  assign gap_err  = r_gap_err;

endmodule

// File: tb/tb_linebuffer_2x2_frame_ctrl.sv
// Directed bench for linebuffer_2x2_frame_ctrl with a window scoreboard:
// each window-completing beat queues its expected cycle and coordinates,
// and a monitor pops and compares whenever win_valid is seen.
module tb_linebuffer_2x2_frame_ctrl;

  localparam int WIN_LAT = 3;

  logic       clk;
  logic       rst;
  logic [2:0] cfg_sel;
  logic       start;
  logic       in_valid;
  logic [2:0] lb_sel;
  logic       in_ready;
  logic       win_valid;
  logic [6:0] win_row;
  logic [6:0] win_col;
  logic       busy;
  logic       done;
  logic       cfg_err;
  logic       gap_err;

  linebuffer_2x2_frame_ctrl #(.WIN_LAT(WIN_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_sel   (cfg_sel),
    .start     (start),
    .in_valid  (in_valid),
    .lb_sel    (lb_sel),
    .in_ready  (in_ready),
    .win_valid (win_valid),
    .win_row   (win_row),
    .win_col   (win_col),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err),
    .gap_err   (gap_err)
  );

  typedef struct {
    int cyc;
    int row;
    int col;
  } win_t;

  win_t       q[$];
  win_t       mon_e;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         nwin = 0;
  int         first_cyc = -1;
  int         last_row = -1;
  int         last_col = -1;
  int         lbsel_bad = 0;
  logic [2:0] exp_lbsel = 3'd0;
  int         beat0_cyc = 0;
  int         last_beat_cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Window monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (busy === 1'b1 && lb_sel !== exp_lbsel) lbsel_bad++;
    if (win_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_window", 32'd1, 32'd0);
      end else begin
        mon_e = q.pop_front();
        chk("win_cycle", cyc, mon_e.cyc);
        chk("win_row", {25'd0, win_row}, mon_e.row);
        chk("win_col", {25'd0, win_col}, mon_e.col);
      end
      if (nwin == 0) first_cyc = cyc;
      nwin++;
      last_row = int'(win_row);
      last_col = int'(win_col);
    end
  end

  // Assert start in the current cycle, then check the t+1 response.
  task automatic do_start(input logic [2:0] sel);
    nwin      = 0;
    first_cyc = -1;
    lbsel_bad = 0;
    exp_lbsel = sel;
    start     = 1'b1;
    cfg_sel   = sel;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("start_busy", busy, 1);
    chk("start_in_ready", in_ready, 1);
    chk("start_lb_sel", lb_sel, sel);
    chk("start_gap_clr", gap_err, 0);
    chk("start_done_low", done, 0);
    @(posedge clk); #1;
  endtask

  // Drive n contiguous beats of a w-wide frame; optionally pulse a
  // (to-be-ignored) start on beat mid_start.
  task automatic send_beats(input int w, input int n, input int mid_start);
    win_t e;
    beat0_cyc = cyc;
    for (int i = 0; i < n; i++) begin
      int r;
      int c;
      r        = i / w;
      c        = i % w;
      in_valid = 1'b1;
      start    = (i == mid_start);
      if (i == mid_start) cfg_sel = 3'd2;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        e.cyc = cyc + WIN_LAT;
        e.row = r / 2;
        e.col = c / 2;
        q.push_back(e);
      end
      last_beat_cyc = cyc;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Wait (bounded) for done; leaves the caller at the negedge of the done cycle.
  task automatic wait_done(input int w);
    int dc;
    dc = -1;
    for (int k = 0; k < WIN_LAT + 8 && dc < 0; k++) begin
      @(negedge clk);
      if (done === 1'b1) dc = cyc;
    end
    chk("done_cycle", dc, last_beat_cyc + WIN_LAT + 1);
    chk("busy_low_at_done", busy, 0);
    chk("win_count", nwin, (w / 2) * (w / 2));
    chk("first_win_cycle", first_cyc, beat0_cyc + w + 1 + WIN_LAT);
    chk("last_win_row", last_row, w / 2 - 1);
    chk("last_win_col", last_col, w / 2 - 1);
    chk("sb_empty", q.size(), 0);
    chk("lb_sel_stable", lbsel_bad, 0);
  endtask

  task automatic trim_after(input int c);
    while (q.size() > 0 && q[$].cyc > c) void'(q.pop_back());
  endtask

  initial begin
    #1500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b1;
    cfg_sel  = 3'd0;
    start    = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_lb_sel", lb_sel, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_gap_err", gap_err, 0);
    chk("rst_win_row", win_row, 0);
    chk("rst_win_col", win_col, 0);
    @(posedge clk); #1;

    // W=14 full frame.
    do_start(3'd1);
    send_beats(14, 196, -1);
    wait_done(14);
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_single_pulse", done, 0);
    @(posedge clk); #1;

    // Illegal size codes.
    for (int s = 6; s <= 7; s++) begin
      start   = 1'b1;
      cfg_sel = 3'(s);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("cfg_err_pulse", cfg_err, 1);
      chk("cfg_err_busy", busy, 0);
      chk("cfg_err_lb_sel", lb_sel, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("cfg_err_clears", cfg_err, 0);
      @(posedge clk); #1;
    end

    // W=16 full frame, then a start in the same cycle as done (W=28).
    do_start(3'd0);
    send_beats(16, 256, -1);
    wait_done(16);
    do_start(3'd2);

    // W=28: drop in_valid at beat 100.
    send_beats(28, 100, -1);
    trim_after(cyc);
    @(posedge clk); #1;
    @(negedge clk);
    chk("gap_err_set", gap_err, 1);
    chk("gap_busy_low", busy, 0);
    chk("gap_in_ready_low", in_ready, 0);
    repeat (8) @(negedge clk);
    chk("gap_sb_empty", q.size(), 0);
    chk("gap_err_sticky", gap_err, 1);
    @(posedge clk); #1;

    // W=14 with a start pulsed mid-frame; do_start checks gap_err cleared.
    do_start(3'd1);
    send_beats(14, 196, 30);
    wait_done(14);
    @(posedge clk); #1;

    // W=14 with reset asserted at beat 50.
    do_start(3'd1);
    send_beats(14, 50, -1);
    in_valid = 1'b1;
    rst      = 1'b1;
    trim_after(cyc);
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mrst_lb_sel", lb_sel, 0);
    chk("mrst_in_ready", in_ready, 0);
    chk("mrst_win_valid", win_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_cfg_err", cfg_err, 0);
    chk("mrst_gap_err", gap_err, 0);
    chk("mrst_win_row", win_row, 0);
    chk("mrst_win_col", win_col, 0);
    repeat (6) @(negedge clk);
    chk("mrst_sb_empty", q.size(), 0);
    @(posedge clk); #1;

    // W=224 full frame.
    do_start(3'd5);
    send_beats(224, 50176, -1);
    wait_done(224);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
